// File: rtl/psum_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_collector_if
// Purpose  : Bundles the tile control, partial-sum input stream and
//            activation output stream of psum_collector.
// Ports    : master - the environment side (drives start/cfg, in_psum,
//                     in_valid, out_ready)
//            slave  - the collector side (drives in_ready, out_act,
//                     out_valid, busy, done)
// Revision : 1.0 - initial release
// ============================================================================
interface psum_collector_if #(
   parameter int ACC_W = 21,
   parameter int ACT_W = 8
) ();
   logic                    start;
   logic [3:0]              cfg_passes;
   logic [4:0]              cfg_shift;
   logic signed [ACC_W-1:0] in_psum;
   logic                    in_valid;
   logic                    in_ready;
   logic [ACT_W-1:0]        out_act;
   logic                    out_valid;
   logic                    out_ready;
   logic                    busy;
   logic                    done;

   modport master (
      output start, cfg_passes, cfg_shift, in_psum, in_valid, out_ready,
      input  in_ready, out_act, out_valid, busy, done
   );

   modport slave (
      input  start, cfg_passes, cfg_shift, in_psum, in_valid, out_ready,
      output in_ready, out_act, out_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/psum_collector.sv
`default_nettype none
// ============================================================================
// Module   : psum_collector
// Purpose  : Drain stage for a PE column. Accumulates signed partial sums
//            per output pixel across several input-channel passes, then
//            requantizes each final sum (round-half-up shift + clamp) to an
//            activation and queues it in a small output FIFO.
// Ports    : clk  - clock, all state on rising edge
//            rst  - synchronous active-high reset
//            bus  - psum_collector_if.slave: start/cfg_passes/cfg_shift,
//                   in_psum/in_valid/in_ready, out_act/out_valid/out_ready,
//                   busy, done
// Macro    : PSUM_RELU_EN - defined: ReLU clamp to [0, 2^ACT_W-1];
//                           undefined: signed clamp to ACT_W bits
// Revision : 1.0 - initial release
// ============================================================================
module psum_collector #(
   parameter int ACC_W      = 21,
   parameter int SUM_W      = 25,
   parameter int ACT_W      = 8,
   parameter int NUM_PIX    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   psum_collector_if.slave   bus
);
   localparam int PIX_W = $clog2(NUM_PIX);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

`ifdef PSUM_RELU_EN
   localparam logic signed [SUM_W:0] ACT_MAX = (SUM_W+1)'((1 << ACT_W) - 1);
   localparam logic signed [SUM_W:0] ACT_MIN = '0;
`else
   localparam logic signed [SUM_W:0] ACT_MAX = (SUM_W+1)'((1 << (ACT_W-1)) - 1);
   localparam logic signed [SUM_W:0] ACT_MIN = (SUM_W+1)'(-(1 << (ACT_W-1)));
`endif

   logic [1:0]              state;
   logic [3:0]              passes_q;
   logic [4:0]              shift_q;
   logic [PIX_W-1:0]        pix_cnt;
   logic [3:0]              pass_cnt;

   logic signed [SUM_W-1:0] acc_buf [NUM_PIX];
   logic signed [SUM_W-1:0] x;
   logic signed [SUM_W-1:0] sum_next;
   logic signed [SUM_W-1:0] post_sum;
   logic                    post_valid;

   logic [ACT_W-1:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W:0]          fifo_count;
   logic [PTR_W:0]          occupancy;

   logic                    final_pass;
   logic                    last_pix;
   logic                    accept;
   logic                    all_empty;
   logic                    push;
   logic                    pop;

   logic signed [SUM_W:0]   ext_sum;
   logic signed [SUM_W:0]   round_add;
   logic signed [SUM_W:0]   shifted;
   logic [ACT_W-1:0]        act;

   assign x          = {{(SUM_W-ACC_W){bus.in_psum[ACC_W-1]}}, bus.in_psum};
   assign final_pass = (pass_cnt == passes_q);
   assign last_pix   = (pix_cnt == PIX_W'(NUM_PIX - 1));
   assign sum_next   = (pass_cnt == 4'd0) ? x : acc_buf[pix_cnt] + x;

   // During the final pass every accepted sample becomes a FIFO entry, so the
   // sample in the post-process register must already hold a slot. A pop in
   // the same cycle is deliberately not counted to keep this path short.
   assign occupancy  = fifo_count + {{PTR_W{1'b0}}, post_valid};
   assign bus.in_ready = (state == S_RUN) &&
                         (!final_pass || (occupancy < (PTR_W+1)'(FIFO_DEPTH)));
   assign accept     = bus.in_valid && bus.in_ready;
   assign all_empty  = !post_valid && (fifo_count == '0);

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         passes_q <= '0;
         shift_q  <= '0;
         pix_cnt  <= '0;
         pass_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  passes_q <= bus.cfg_passes;
                  shift_q  <= bus.cfg_shift;
                  pix_cnt  <= '0;
                  pass_cnt <= '0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (last_pix) begin
                     pix_cnt  <= '0;
                     pass_cnt <= pass_cnt + 4'd1;
                     if (final_pass) state <= S_DRAIN;
                  end else begin
                     pix_cnt <= pix_cnt + PIX_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (all_empty) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pass 0 overwrites whatever a previous (possibly aborted) tile left here,
   // so the buffer needs no reset. The final pass bypasses the buffer.
   always_ff @(posedge clk) begin
      if (!rst && accept && !final_pass) acc_buf[pix_cnt] <= sum_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         post_valid <= 1'b0;
         post_sum   <= '0;
      end else begin
         post_valid <= accept && final_pass;
         if (accept && final_pass) post_sum <= sum_next;
      end
   end

   // -------------------------------------------------------------- requantize
   // One extra bit of headroom so adding the rounding constant never wraps.
   assign ext_sum   = {post_sum[SUM_W-1], post_sum};
   assign round_add = (shift_q == 5'd0) ? '0 : ((SUM_W+1)'(1) <<< (shift_q - 5'd1));
   assign shifted   = (ext_sum + round_add) >>> shift_q;

   always_comb begin
      act = shifted[ACT_W-1:0];
      if (shifted < ACT_MIN)      act = ACT_MIN[ACT_W-1:0];
      else if (shifted > ACT_MAX) act = ACT_MAX[ACT_W-1:0];
   end

   // -------------------------------------------------------------------- FIFO
   assign push = post_valid;
   assign pop  = (fifo_count != '0) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= act;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // The head is masked while empty so out_act reads zero out of reset.
   assign bus.out_valid = (fifo_count != '0);
   assign bus.out_act   = bus.out_valid ? fifo_mem[rd_ptr] : '0;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DRAIN) && all_empty;
endmodule
`default_nettype wire

// File: doc/psum_collector.md
# psum_collector

Downstream drain stage for a PE column: accepts the 21-bit partial sums from the bottom PE's partial-sum output, one per output pixel.
- Accumulates them across multiple input-channel passes in a per-pixel buffer.
- Requantizes each final sum to an 8-bit activation with round-half-up right shift, ReLU and saturation.
- Queues results in a small FIFO toward the activation write-back path.

## Interface
Parameters:
- ACC_W, 21, width of incoming partial sum (signed, matches PE accumulation width)
- SUM_W, 25, width of accumulation buffer entries; must be ≥ ACC_W+4
- ACT_W, 8, output activation width
- NUM_PIX, 16, output pixels per pass (buffer depth), power of 2
- FIFO_DEPTH, 4, output FIFO entries, power of 2

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begins a tile; ignored unless busy=0
- cfg_passes  in  4  number of passes minus 1, latched on start
- cfg_shift  in  5  right-shift amount 0..24, latched on start
- in_psum  in  ACC_W  signed partial sum from PE column
- in_valid  in  1  in_psum valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- out_act  out  ACT_W  requantized activation (FIFO head)
- out_valid  out  1  FIFO not empty
- out_ready  in  1  pop when out_valid & out_ready
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of tile

## Operation
- State machine IDLE → RUN → DRAIN → IDLE.
  - IDLE: start=1 latches cfg_passes/cfg_shift, clears pix_cnt and pass_cnt, and enters RUN.
  - RUN: processes accepted samples.
  - DRAIN: waits until the post-process register and the FIFO are both empty, then pulses done for 1 cycle and returns to IDLE.
- Accepted sample in RUN, with x = sign-extended in_psum to SUM_W:
  - pass_cnt==0 and not final: buf[pix_cnt] ← x.
  - 0<pass_cnt<final: buf[pix_cnt] ← buf[pix_cnt]+x.
  - final pass (pass_cnt==cfg_passes_q): sum = (pass_cnt==0 ? x : buf[pix_cnt]+x), loaded into the post-process register. The buffer is not written.
- pix_cnt increments per accepted sample and wraps from NUM_PIX-1 to 0, incrementing pass_cnt.
  - Acceptance of the last pixel in the final pass → DRAIN.
- Post-process arithmetic on sum (signed SUM_W):
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed arithmetically in SUM_W+1 bits.
  - Then clamp as defined under Configuration.
  - Result is written to the FIFO one cycle after the post-process register loads.
- in_ready = (state==RUN) && (pass_cnt≠cfg_passes_q || fifo_count + post_valid < FIFO_DEPTH). A same-cycle pop is not credited.
- FIFO behaviour:
  - Push and pop in the same cycle both take effect.
  - A push to a full FIFO cannot occur by construction.
  - Pop on empty is ignored.
- start while busy=1: ignored, cfg unchanged.
- Accumulation cannot overflow given SUM_W ≥ ACC_W+4 (≤16 passes).

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_act=0, busy=0, done=0.
  - State IDLE; pix_cnt, pass_cnt, fifo pointers/count and post_valid = 0.
  - Buffer contents are not reset; pass 0 overwrites them.
- rst asserted mid-tile: next cycle is IDLE with the FIFO empty; pending results are discarded and done is not pulsed.
- start at cycle t → busy=1 and in_ready=1 at t+1.
- Final-pass sample accepted at t:
  - post-process register valid at t+1;
  - FIFO write at t+1 edge;
  - out_valid=1 and out_act valid at t+2 if the FIFO was empty.
- Sustained throughput is one sample/cycle while out_ready=1.
- done is asserted in the cycle DRAIN observes empty; busy falls the following cycle.

## Configuration
- PSUM_RELU_EN defined: ReLU output. r<0 → 0; r>2^ACT_W−1 → 2^ACT_W−1 (255); out_act is unsigned.
- PSUM_RELU_EN undefined: signed saturation to [−2^(ACT_W−1), 2^(ACT_W−1)−1] = [−128, 127]; out_act is two's complement.

## Test plan
- Single pass (cfg_passes=0, shift=0), in_psum = pixel index 0..15, out_ready=1 → 16 outputs 0..15 in order, first out_valid 2 cycles after first accept, then done.
- Three passes (cfg_passes=2, shift=2), each pixel receives 5, 6, 7 → sum 18, (18+2)>>2 = 5 on all 16 outputs.
- Rounding/clamp (ReLU build), shift=4:
  - psum −100 → 0;
  - psum 24 → (24+8)>>4 = 2;
  - psum 100000 → 255.
  - Non-ReLU build: −100 → (−100+8)>>>4 = −6 (0xFA); 100000 → 127.
- Backpressure: out_ready=0 during the final pass → exactly FIFO_DEPTH samples accepted, then in_ready=0. Releasing out_ready resumes with no loss or duplication; all 16 outputs are correct and in order.
- start pulsed during RUN with different cfg → ignored, results match the original cfg. rst asserted at pixel 7 of pass 1 → IDLE, out_valid=0 next cycle. A new tile then produces correct results and ignores stale buffer contents.
